// File: rtl/relu_share_arbiter.sv
// relu_share_arbiter
// Round-robin arbiter that time-shares one external registered ReLU neuron
// among NUM_REQ requesters. One operand is accepted per cycle over
// valid/ready, driven onto neuron_in, and its requester ID travels down a tag
// pipeline aligned with the neuron latency so each result returns tagged.
// A RUN/DRAIN/HOLD flush controller lets upstream logic quiesce the neuron.
//
// Optional build macro: RELU_SHARE_STATS_EN adds stat_clear, stat_issued and
// stat_clipped (saturating 16-bit transfer and zero-result counters).

module relu_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int NEURON_LAT = 1,
  parameter int ID_W       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         neuron_in,
  input  logic [DATA_W-1:0]         neuron_out,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      busy
`ifdef RELU_SHARE_STATS_EN
  ,
  input  logic                      stat_clear,
  output logic [15:0]               stat_issued,
  output logic [15:0]               stat_clipped
`endif
);

  // Tag stage NEURON_LAT lines up with the registered neuron output.
  localparam int NSTG = NEURON_LAT + 1;
  localparam int LAST = NEURON_LAT;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]           neuron_in_q, neuron_in_d;
  logic [NSTG-1:0]             tag_vld_q, tag_vld_d;
  logic [NSTG-1:0][ID_W-1:0]   tag_id_q, tag_id_d;
  logic                        resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]             resp_id_q, resp_id_d;
  logic [DATA_W-1:0]           resp_data_q, resp_data_d;
  logic                        flush_done_q, flush_done_d;

  logic                        grant_en;
  logic                        hi_found, lo_found;
  logic [ID_W-1:0]             hi_idx, lo_idx;
  logic                        xfer;
  logic [ID_W-1:0]             grant_idx;
  logic [DATA_W-1:0]           grant_data;
  logic                        tag_empty;

  // Round-robin search: first valid at or above rr_ptr, else lowest valid.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    grant_en = reset && (state_q == ST_RUN) && !flush;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
      end
      if (req_valid[i] && !hi_found && (ID_W'(i) >= rr_ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(i);
      end
    end
    xfer      = grant_en && (hi_found || lo_found);
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // One-hot ready, operand mux and pointer advance for the granted requester.
  always_comb begin
    req_ready  = '0;
    grant_data = '0;
    rr_ptr_d   = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        req_ready[i] = xfer;
        grant_data   = req_data[i*DATA_W +: DATA_W];
      end
    end
    if (xfer) begin
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // Issue into the neuron, shift the tag pipeline, capture the tagged result.
  always_comb begin
    neuron_in_d = xfer ? grant_data : '0;
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = xfer;
    tag_id_d[0]  = grant_idx;
    for (int s = 1; s < NSTG; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
    resp_valid_d = tag_vld_q[LAST];
    resp_id_d    = tag_vld_q[LAST] ? tag_id_q[LAST] : resp_id_q;
    resp_data_d  = tag_vld_q[LAST] ? neuron_out     : resp_data_q;
  end

  assign tag_empty = ~|tag_vld_q;

  // Flush controller next state: RUN -> DRAIN on flush, DRAIN -> HOLD once
  // the tag pipeline is empty (with a done pulse), HOLD -> RUN on flush low.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (tag_empty) begin
          flush_done_d = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!flush) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers; an asynchronous reset drops every in-flight result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      rr_ptr_q     <= '0;
      neuron_in_q  <= '0;
      // NOTE: the tag pipeline is small and must be cleared, otherwise a
      // stale valid bit would emit a response after reset; wide data-only
      // storage would normally be left unreset.
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      neuron_in_q  <= neuron_in_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign neuron_in  = neuron_in_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign flush_done = flush_done_q;
  // Includes the stage 0 write happening this cycle.
  assign busy       = xfer | ~tag_empty;

`ifdef RELU_SHARE_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_clipped_q, stat_clipped_d;

  // Saturating counters; clear wins over increment.
  always_comb begin
    stat_issued_d  = stat_issued_q;
    stat_clipped_d = stat_clipped_q;
    if (stat_clear) begin
      stat_issued_d  = '0;
      stat_clipped_d = '0;
    end else begin
      if (xfer && (stat_issued_q != 16'hFFFF)) begin
        stat_issued_d = stat_issued_q + 16'd1;
      end
      if (resp_valid_q && (resp_data_q == '0) && (stat_clipped_q != 16'hFFFF)) begin
        stat_clipped_d = stat_clipped_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_issued_q  <= '0;
      stat_clipped_q <= '0;
    end else begin
      stat_issued_q  <= stat_issued_d;
      stat_clipped_q <= stat_clipped_d;
    end
  end

  assign stat_issued  = stat_issued_q;
  assign stat_clipped = stat_clipped_q;
`endif

endmodule

// File: tb/tb_relu_share_arbiter.sv
// Testbench for relu_share_arbiter: a behavioural registered ReLU neuron and a
// cycle-indexed scoreboard model (response due NEURON_LAT+2 cycles after the
// cycle an operand is presented) drive per-scenario comparisons.

module tb_relu_share_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 8;
  localparam int NEURON_LAT = 1;
  localparam int ID_W       = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         neuron_in;
  logic [DATA_W-1:0]         neuron_out;
  logic                      resp_valid;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_data;
  logic                      flush;
  logic                      flush_done;
  logic                      busy;
`ifdef RELU_SHARE_STATS_EN
  logic                      stat_clear = 1'b0;
  logic [15:0]               stat_issued;
  logic [15:0]               stat_clipped;
`endif

  relu_share_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .NEURON_LAT(NEURON_LAT), .ID_W(ID_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .neuron_in(neuron_in), .neuron_out(neuron_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .flush(flush), .flush_done(flush_done), .busy(busy)
`ifdef RELU_SHARE_STATS_EN
    , .stat_clear(stat_clear), .stat_issued(stat_issued), .stat_clipped(stat_clipped)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

  // Behavioural shared neuron: registered ReLU with NEURON_LAT cycles delay.
  logic [DATA_W-1:0] nl_pipe [NEURON_LAT];
  initial for (int s = 0; s < NEURON_LAT; s++) nl_pipe[s] = '0;
  always @(posedge clk) begin
    nl_pipe[0] <= relu(neuron_in);
    for (int s = 1; s < NEURON_LAT; s++) nl_pipe[s] <= nl_pipe[s-1];
  end
  assign neuron_out = nl_pipe[NEURON_LAT-1];

  // Reference model state.
  typedef struct {
    int                due;
    int                id;
    logic [DATA_W-1:0] opnd;
  } resp_t;

  resp_t             sb[$];
  int                m_rr, m_mode, m_rid, cyc;
  bit                m_fd;
  logic [DATA_W-1:0] m_nin, m_rdata;

  int total = 0;
  int bad   = 0;

  logic [NUM_REQ-1:0] exp_ready, obs_ready;
  logic               exp_rv, obs_rv, exp_busy, obs_busy, exp_fd, obs_fd;
  logic [ID_W-1:0]    exp_rid, obs_rid;
  logic [DATA_W-1:0]  exp_rdata, obs_rdata, exp_nin, obs_nin;
  int                 exp_gid;

  function automatic void clear_model();
    sb.delete();
    m_rr = 0; m_mode = 0; m_rid = 0; m_fd = 1'b0;
    m_nin = '0; m_rdata = '0;
  endfunction

  function automatic logic [NUM_REQ*DATA_W-1:0] put(
      input logic [NUM_REQ*DATA_W-1:0] base, input int i, input logic [DATA_W-1:0] x);
    logic [NUM_REQ*DATA_W-1:0] r;
    r = base;
    r[i*DATA_W +: DATA_W] = x;
    return r;
  endfunction

  // Drive one cycle of stimulus, sample the DUT mid-cycle, compute what the
  // model expects for this cycle, then advance the model across the edge.
  task automatic tick(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*DATA_W-1:0] d,
                      input logic f);
    resp_t e;
    req_valid = v; req_data = d; flush = f;
    @(negedge clk);
    exp_ready = '0;
    exp_gid   = -1;
    if (reset && m_mode == 0 && !f) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (exp_gid < 0 && v[(m_rr + k) % NUM_REQ]) exp_gid = (m_rr + k) % NUM_REQ;
    end
    if (exp_gid >= 0) exp_ready[exp_gid] = 1'b1;
    exp_rv = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_rv  = 1'b1;
      m_rid   = sb[0].id;
      m_rdata = relu(sb[0].opnd);
      void'(sb.pop_front());
    end
    exp_rid   = ID_W'(m_rid);
    exp_rdata = m_rdata;
    exp_nin   = m_nin;
    exp_fd    = m_fd;
    exp_busy  = (exp_gid >= 0) || (sb.size() > 0);
    obs_ready = req_ready; obs_rv = resp_valid; obs_rid = resp_id;
    obs_rdata = resp_data; obs_nin = neuron_in; obs_busy = busy; obs_fd = flush_done;
    if (reset) begin
      m_fd = 1'b0;
      if (exp_gid >= 0) begin
        e.due = cyc + NEURON_LAT + 2; e.id = exp_gid; e.opnd = d[exp_gid*DATA_W +: DATA_W];
        sb.push_back(e);
        m_rr  = (exp_gid + 1) % NUM_REQ;
        m_nin = e.opnd;
      end else begin
        m_nin = '0;
      end
      case (m_mode)
        0: if (f) m_mode = 1;
        1: if (sb.size() == 0) begin m_fd = 1'b1; m_mode = 2; end
        2: if (!f) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_model();
    tick('0, '0, 1'b0);
    tick('0, '0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_model();
    for (int t = 0; t < 2; t++) begin
      tick('1, '1, 1'b0);
      total++; if (obs_ready !== '0) begin bad++; $display("FAIL reset_ready t=%0d got=%b want=0", t, obs_ready); end
      total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL reset_busy t=%0d got=%b want=0", t, obs_busy); end
    end
    reset = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick('0, '0, 1'b0);
      total++;
      if ({obs_ready, obs_rv, obs_rid, obs_rdata, obs_nin, obs_fd, obs_busy} !== '0) begin
        bad++;
        $display("FAIL idle_outputs t=%0d got ready=%b rv=%b id=%0d data=%h nin=%h fd=%b busy=%b want all 0",
                 t, obs_ready, obs_rv, obs_rid, obs_rdata, obs_nin, obs_fd, obs_busy);
      end
    end
  endtask

  task automatic test_single_requester();
    logic [DATA_W-1:0] vals [4];
    logic [DATA_W-1:0] want [4];
    vals = '{8'hF6, 8'd5, 8'hFD, 8'd12};
    want = '{8'd0, 8'd5, 8'd0, 8'd12};
    apply_reset();
    for (int t = 0; t < 10; t++) begin
      if (t < 4) tick(4'b0100, put('0, 2, vals[t]), 1'b0);
      else       tick('0, '0, 1'b0);
      total++;
      if (obs_ready !== ((t < 4) ? 4'b0100 : 4'b0000)) begin
        bad++; $display("FAIL single_ready t=%0d got=%b", t, obs_ready);
      end
      total++;
      if (obs_rv !== (t >= 3 && t <= 6)) begin
        bad++; $display("FAIL single_resp_valid t=%0d got=%b want=%b", t, obs_rv, (t >= 3 && t <= 6));
      end
      if (t >= 3 && t <= 6) begin
        total++;
        if (obs_rid !== 2'd2 || obs_rdata !== want[t-3]) begin
          bad++; $display("FAIL single_resp t=%0d got id=%0d data=%0d want id=2 data=%0d",
                          t, obs_rid, obs_rdata, want[t-3]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [DATA_W-1:0] ops [8];
    int rid_q[$];
    logic [DATA_W-1:0] rd_q[$];
    logic [NUM_REQ*DATA_W-1:0] d;
    apply_reset();
    for (int t = 0; t < 14; t++) begin
      d = {$urandom, $urandom};
      if (t < 8) begin
        ops[t] = d[(t % NUM_REQ)*DATA_W +: DATA_W];
        tick('1, d, 1'b0);
        total++;
        if (obs_ready !== 4'(1 << (t % NUM_REQ))) begin
          bad++; $display("FAIL rr_grant t=%0d got=%b want=%b", t, obs_ready, 4'(1 << (t % NUM_REQ)));
        end
      end else begin
        tick('0, '0, 1'b0);
      end
      if (obs_rv) begin rid_q.push_back(int'(obs_rid)); rd_q.push_back(obs_rdata); end
    end
    total++;
    if (rid_q.size() != 8) begin bad++; $display("FAIL rr_resp_count got=%0d want=8", rid_q.size()); end
    for (int k = 0; k < 8 && k < rid_q.size(); k++) begin
      total++;
      if (rid_q[k] != k % NUM_REQ || rd_q[k] !== relu(ops[k])) begin
        bad++; $display("FAIL rr_resp k=%0d got id=%0d data=%h want id=%0d data=%h",
                        k, rid_q[k], rd_q[k], k % NUM_REQ, relu(ops[k]));
      end
    end
  endtask

  task automatic test_wrap_skip();
    logic [NUM_REQ-1:0] vv [4];
    logic [NUM_REQ-1:0] want [4];
    vv   = '{4'b0100, 4'b0010, 4'b0110, 4'b1001};
    want = '{4'b0100, 4'b0010, 4'b0100, 4'b1000};
    apply_reset();
    for (int t = 0; t < 4; t++) begin
      tick(vv[t], {$urandom}, 1'b0);
      total++;
      if (obs_ready !== want[t]) begin
        bad++; $display("FAIL wrap_grant t=%0d got=%b want=%b", t, obs_ready, want[t]);
      end
    end
    for (int t = 0; t < 5; t++) begin
      tick('0, '0, 1'b0);
      total++;
      if (obs_rv !== exp_rv || obs_rid !== exp_rid || obs_rdata !== exp_rdata) begin
        bad++; $display("FAIL wrap_resp t=%0d got rv=%b id=%0d data=%h want rv=%b id=%0d data=%h",
                        t, obs_rv, obs_rid, obs_rdata, exp_rv, exp_rid, exp_rdata);
      end
    end
  endtask

  task automatic test_flush();
    int n_rv, n_fd, last_rv_t, fd_t, first_grant_t;
    apply_reset();
    n_rv = 0; n_fd = 0; last_rv_t = -1; fd_t = -1;
    for (int t = 0; t < 11; t++) begin
      tick('1, {$urandom}, (t >= 3));
      if (t >= 3) begin
        total++;
        if (obs_ready !== '0) begin bad++; $display("FAIL flush_ready t=%0d got=%b want=0", t, obs_ready); end
      end
      total++;
      if (obs_rv !== exp_rv || obs_rdata !== exp_rdata || obs_fd !== exp_fd) begin
        bad++; $display("FAIL flush_model t=%0d got rv=%b data=%h fd=%b want rv=%b data=%h fd=%b",
                        t, obs_rv, obs_rdata, obs_fd, exp_rv, exp_rdata, exp_fd);
      end
      if (obs_rv) begin n_rv++; last_rv_t = t; end
      if (obs_fd) begin n_fd++; fd_t = t; end
    end
    total++;
    if (n_rv != 3 || n_fd != 1 || fd_t != last_rv_t + 1) begin
      bad++; $display("FAIL flush_drain got resps=%0d pulses=%0d fd_t=%0d last_rv_t=%0d want 3 1 last+1",
                      n_rv, n_fd, fd_t, last_rv_t);
    end
    // Flush released while in HOLD: one more cycle without grants.
    tick('1, {$urandom}, 1'b0);
    total++;
    if (obs_ready !== '0) begin bad++; $display("FAIL hold_ready got=%b want=0", obs_ready); end
    // Flush pulsed for one cycle with one operand in flight.
    n_fd = 0; fd_t = -1; first_grant_t = -1;
    for (int t = 0; t < 7; t++) begin
      tick('1, {$urandom}, (t == 1));
      if (t == 0) begin
        total++;
        if (obs_ready !== 4'b1000) begin bad++; $display("FAIL resume_grant got=%b want=1000", obs_ready); end
      end
      if (obs_fd) begin n_fd++; fd_t = t; end
      if (t >= 1 && first_grant_t < 0 && obs_ready !== '0) first_grant_t = t;
    end
    total++;
    if (n_fd != 1 || fd_t != 4 || first_grant_t != 5) begin
      bad++; $display("FAIL drain_release got pulses=%0d fd_t=%0d first_grant=%0d want 1 4 5",
                      n_fd, fd_t, first_grant_t);
    end
  endtask

  task automatic test_reset_mid_flight();
    int n_rv;
    apply_reset();
    tick('1, {$urandom}, 1'b0);
    tick('1, {$urandom}, 1'b0);
    reset = 1'b0;
    clear_model();
    tick('0, '0, 1'b0);
    reset = 1'b1;
    n_rv = 0;
    for (int t = 0; t < 6; t++) begin
      tick('0, '0, 1'b0);
      if (obs_rv) n_rv++;
      total++;
      if (obs_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy t=%0d got=%b want=0", t, obs_busy); end
    end
    total++;
    if (n_rv != 0) begin bad++; $display("FAIL midreset_resp got=%0d responses want=0", n_rv); end
    tick('1, {$urandom}, 1'b0);
    total++;
    if (obs_ready !== 4'b0001) begin bad++; $display("FAIL midreset_rr got=%b want=0001", obs_ready); end
  endtask

  task automatic test_random();
    logic f;
    f = 1'b0;
    apply_reset();
    for (int t = 0; t < 420; t++) begin
      if (t < 400 && $urandom_range(0, 14) == 0) f = ~f;
      if (t >= 400) f = 1'b0;
      tick((t < 400) ? NUM_REQ'($urandom_range(0, 15)) : '0, {$urandom}, f);
      total++;
      if (obs_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready t=%0d got=%b want=%b", t, obs_ready, exp_ready); end
      total++;
      if (obs_rv !== exp_rv || obs_rid !== exp_rid || obs_rdata !== exp_rdata) begin
        bad++; $display("FAIL rnd_resp t=%0d got rv=%b id=%0d data=%h want rv=%b id=%0d data=%h",
                        t, obs_rv, obs_rid, obs_rdata, exp_rv, exp_rid, exp_rdata);
      end
      total++;
      if (obs_nin !== exp_nin) begin bad++; $display("FAIL rnd_neuron_in t=%0d got=%h want=%h", t, obs_nin, exp_nin); end
      total++;
      if (obs_busy !== exp_busy || obs_fd !== exp_fd) begin
        bad++; $display("FAIL rnd_busy_fd t=%0d got busy=%b fd=%b want busy=%b fd=%b",
                        t, obs_busy, obs_fd, exp_busy, exp_fd);
      end
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; flush = 1'b0; cyc = 0;
    clear_model();
    @(posedge clk);
    #1;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_wrap_skip();
    test_flush();
    test_reset_mid_flight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
